// File: rtl/rvfi_imem_track_check.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_imem_track_check
// Purpose  : Self-learning instruction-memory consistency checker on the RVFI
//            retirement bus. Tracks NSLOT halfword slots, learns each slot from
//            its first covering fetch, follows stores and FENCE.I, checks the
//            retirement order sequence and captures the first error.
// Revision : 1.0 - initial release
// ============================================================================
module rvfi_imem_track_check #(
  parameter int XLEN  = 32,
  parameter int NRET  = 1,
  parameter int NSLOT = 2,
  parameter int WMODE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NSLOT*XLEN-1:0]     slot_addr,
  input  logic [NRET-1:0]           rvfi_valid,
  input  logic [NRET*64-1:0]        rvfi_order,
  input  logic [NRET*32-1:0]        rvfi_insn,
  input  logic [NRET*XLEN-1:0]      rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]      rvfi_mem_addr,
  input  logic [NRET*XLEN/8-1:0]    rvfi_mem_wmask,
  input  logic [NRET*XLEN-1:0]      rvfi_mem_wdata,
  output logic                      err,
  output logic [1:0]                err_code,
  output logic [63:0]               err_order,
  output logic [$clog2(NSLOT):0]    err_slot,
  output logic [31:0]               chk_count
);

  localparam int BW = XLEN / 8;
  localparam int OB = $clog2(BW);
  localparam int SW = $clog2(NSLOT) + 1;

  localparam logic [1:0] CODE_MISMATCH = 2'd1;
  localparam logic [1:0] CODE_WSTRICT  = 2'd2;
  localparam logic [1:0] CODE_ORDER    = 2'd3;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_VALID = 2'd1,
    S_STALE = 2'd2
  } slot_state_t;

  // Registered state
  slot_state_t    st_q  [NSLOT];
  logic [15:0]    old_q [NSLOT];
  logic [15:0]    new_q [NSLOT];
  logic           base_q;
  logic [63:0]    exp_q;
  logic           err_q;
  logic [1:0]     code_q;
  logic [63:0]    eorder_q;
  logic [SW-1:0]  eslot_q;
  logic [31:0]    chk_q;

  // Next-state values
  slot_state_t    st_d  [NSLOT];
  logic [15:0]    old_d [NSLOT];
  logic [15:0]    new_d [NSLOT];
  logic           base_d;
  logic [63:0]    exp_d;
  logic           err_d;
  logic [1:0]     code_d;
  logic [63:0]    eorder_d;
  logic [SW-1:0]  eslot_d;
  logic [31:0]    chk_d;

  // Per-channel / per-slot scratch values used while walking the channels
  logic [31:0]     ch_insn;
  logic [63:0]     ch_order;
  logic [XLEN-1:0] ch_pc;
  logic [XLEN-1:0] ch_addr;
  logic [XLEN-1:0] ch_wdata;
  logic [BW-1:0]   ch_wmask;
  logic [XLEN-1:0] slot_a;
  logic [OB-1:0]   off_lo;
  logic [OB-1:0]   off_hi;
  logic            lo_hit;
  logic            hi_hit;
  logic [15:0]     fval;
  logic            same_word;
  logic            byte_lo;
  logic            byte_hi;
  logic [15:0]     merged;
  logic            is_fencei;
  logic            mis;
  logic [SW-1:0]   mis_slot;
  logic            ws;
  logic [SW-1:0]   ws_slot;
  logic            ord_bad;

  // Walk the retirement channels in ascending order with sequential semantics
  always_comb begin
    st_d      = st_q;
    old_d     = old_q;
    new_d     = new_q;
    base_d    = base_q;
    exp_d     = exp_q;
    err_d     = err_q;
    code_d    = code_q;
    eorder_d  = eorder_q;
    eslot_d   = eslot_q;
    chk_d     = chk_q;
    ch_insn   = '0;
    ch_order  = '0;
    ch_pc     = '0;
    ch_addr   = '0;
    ch_wdata  = '0;
    ch_wmask  = '0;
    slot_a    = '0;
    off_lo    = '0;
    off_hi    = '0;
    lo_hit    = 1'b0;
    hi_hit    = 1'b0;
    fval      = '0;
    same_word = 1'b0;
    byte_lo   = 1'b0;
    byte_hi   = 1'b0;
    merged    = '0;
    is_fencei = 1'b0;
    mis       = 1'b0;
    mis_slot  = '0;
    ws        = 1'b0;
    ws_slot   = '0;
    ord_bad   = 1'b0;

    for (int ch = 0; ch < NRET; ch++) begin
      if (rvfi_valid[ch]) begin
        ch_insn  = rvfi_insn[ch*32 +: 32];
        ch_order = rvfi_order[ch*64 +: 64];
        ch_pc    = rvfi_pc_rdata[ch*XLEN +: XLEN];
        ch_addr  = rvfi_mem_addr[ch*XLEN +: XLEN];
        ch_wdata = rvfi_mem_wdata[ch*XLEN +: XLEN];
        ch_wmask = rvfi_mem_wmask[ch*BW +: BW];
        mis      = 1'b0;
        mis_slot = '0;
        ws       = 1'b0;
        ws_slot  = '0;
        ord_bad  = 1'b0;

        for (int s = 0; s < NSLOT; s++) begin
          slot_a = slot_addr[s*XLEN +: XLEN] & ~XLEN'(1);
          off_lo = {slot_a[OB-1:1], 1'b0};
          off_hi = {slot_a[OB-1:1], 1'b1};

          // Fetch check: a covering fetch either learns or is compared
          lo_hit = (ch_pc == slot_a);
          hi_hit = (ch_insn[1:0] == 2'b11) && ((ch_pc + XLEN'(2)) == slot_a);
          fval   = lo_hit ? ch_insn[15:0] : ch_insn[31:16];
          if (lo_hit || hi_hit) begin
            if (st_d[s] == S_EMPTY) begin
              st_d[s]  = S_VALID;
              old_d[s] = fval;
            end else begin
              if (chk_d != 32'hFFFF_FFFF) chk_d = chk_d + 32'd1;
              if (!((fval == old_d[s]) ||
                    ((st_d[s] == S_STALE) && (fval == new_d[s])))) begin
                if (!mis) begin
                  mis      = 1'b1;
                  mis_slot = SW'(s);
                end
              end
            end
          end

          // Store update: merge written bytes into the pending content
          same_word = ((ch_addr >> OB) == (slot_a >> OB));
          byte_lo   = same_word && ch_wmask[off_lo];
          byte_hi   = same_word && ch_wmask[off_hi];
          if (byte_lo || byte_hi) begin
            merged = (st_d[s] == S_VALID) ? old_d[s] : new_d[s];
            if (byte_lo) merged[7:0]  = ch_wdata[{off_lo, 3'b000} +: 8];
            if (byte_hi) merged[15:8] = ch_wdata[{off_hi, 3'b000} +: 8];
            new_d[s] = merged;
            if (st_d[s] == S_EMPTY) old_d[s] = merged;
            st_d[s] = S_STALE;
            if ((WMODE == 0) && !ws) begin
              ws      = 1'b1;
              ws_slot = SW'(s);
            end
          end
        end

        // FENCE.I commits every stale slot
        is_fencei = (ch_insn[6:0] == 7'b0001111) && (ch_insn[14:12] == 3'b001);
        if (is_fencei) begin
          for (int s = 0; s < NSLOT; s++) begin
            if (st_d[s] == S_STALE) begin
              st_d[s]  = S_VALID;
              old_d[s] = new_d[s];
            end
          end
        end

        // Order sequence: first retirement sets the baseline, mismatch resyncs
        if (base_d && (ch_order != exp_d)) ord_bad = 1'b1;
        base_d = 1'b1;
        exp_d  = ch_order + 64'd1;

        // First-error capture with per-channel priority
        if (!err_d && (mis || ws || ord_bad)) begin
          err_d    = 1'b1;
          eorder_d = ch_order;
          if (mis) begin
            code_d  = CODE_MISMATCH;
            eslot_d = mis_slot;
          end else if (ws) begin
            code_d  = CODE_WSTRICT;
            eslot_d = ws_slot;
          end else begin
            code_d  = CODE_ORDER;
            eslot_d = '1;
          end
        end
      end
    end
  end

  // State register with synchronous reset overriding same-cycle retirements
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NSLOT; s++) begin
        st_q[s]  <= S_EMPTY;
        old_q[s] <= '0;
        new_q[s] <= '0;
      end
      base_q   <= 1'b0;
      exp_q    <= '0;
      err_q    <= 1'b0;
      code_q   <= '0;
      eorder_q <= '0;
      eslot_q  <= '0;
      chk_q    <= '0;
    end else begin
      st_q     <= st_d;
      old_q    <= old_d;
      new_q    <= new_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      err_q    <= err_d;
      code_q   <= code_d;
      eorder_q <= eorder_d;
      eslot_q  <= eslot_d;
      chk_q    <= chk_d;
    end
  end

  assign err       = err_q;
  assign err_code  = code_q;
  assign err_order = eorder_q;
  assign err_slot  = eslot_q;
  assign chk_count = chk_q;

endmodule
`default_nettype wire
